// File: rtl/gbuff_pkg.sv
// -----------------------------------------------------------------------------
// gbuff_pkg
// Shared types and helpers for the dual-port global buffer.
//   clr_state_t   : clear engine states (IDLE -> CLEAR -> DONE -> IDLE)
//   MAX_DATA_BITS : widest word merge_bytes can handle; callers size-cast
//                   their operands to and from this width.
//   merge_bytes   : byte-wise merge, bytes with be[k]=1 come from new_word.
// -----------------------------------------------------------------------------
package gbuff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  localparam int MAX_DATA_BITS = 1024;
  localparam int MAX_BE_BITS   = MAX_DATA_BITS / 8;

  function automatic logic [MAX_DATA_BITS-1:0] merge_bytes(
    input logic [MAX_DATA_BITS-1:0] old_word,
    input logic [MAX_DATA_BITS-1:0] new_word,
    input logic [MAX_BE_BITS-1:0]   be
  );
    logic [MAX_DATA_BITS-1:0] result;
    result = old_word;
    for (int k = 0; k < MAX_BE_BITS; k++) begin
      if (be[k]) begin
        result[8*k +: 8] = new_word[8*k +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/gbuff_clear_ctrl.sv
// -----------------------------------------------------------------------------
// gbuff_clear_ctrl
// Clear engine: on clr_req in IDLE, sweeps every word address once, asking
// the array to write zero, then pulses done for one cycle.
//   clk      in  clock
//   rst      in  asynchronous active-high reset
//   clr_req  in  start request (only honoured in IDLE)
//   busy     out high for exactly DEPTH cycles while the sweep runs
//   clr_we   out write-zero strobe for the array
//   clr_addr out word address being cleared
//   done     out one-cycle pulse after the last word is cleared
// -----------------------------------------------------------------------------
module gbuff_clear_ctrl
  import gbuff_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_we,
  output logic [ADDR_BITS-1:0] clr_addr,
  output logic                 done
);

  // Terminal count is compared explicitly instead of waiting for wrap-around.
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};

  clr_state_t           state_reg;
  logic [ADDR_BITS-1:0] cnt_reg;
  logic                 busy_reg;
  logic                 done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (clr_req) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_reg == LAST_ADDR) begin
            state_reg <= DONE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // busy_reg is high exactly while in CLEAR, so it doubles as the write strobe.
  assign busy     = busy_reg;
  assign clr_we   = busy_reg;
  assign clr_addr = cnt_reg;
  assign done     = done_reg;

endmodule

// File: rtl/global_buffer_dp.sv
// -----------------------------------------------------------------------------
// global_buffer_dp
// Simple dual-port buffer (one write port, one read port) with per-byte
// write enables, read latency 1 or 2, selectable same-address collision
// policy and a whole-array clear engine.
//   clk_i       in  clock
//   rst_i       in  asynchronous active-high reset (array contents kept)
//   wr_en_i     in  write request
//   wr_addr_i   in  write word address
//   wr_be_i     in  byte enables, bit k covers wr_data_i[8k+7:8k]
//   wr_data_i   in  write data
//   rd_en_i     in  read request
//   rd_addr_i   in  read word address
//   rd_data_o   out read data, holds when rd_valid_o is low
//   rd_valid_o  out one-cycle pulse, RD_LAT cycles after an accepted read
//   clr_i       in  start clearing the whole array
//   busy_o      out clear running, user requests are dropped
//   clr_done_o  out one-cycle pulse when the clear has finished
// -----------------------------------------------------------------------------
module global_buffer_dp
  import gbuff_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32,
  parameter int RD_LAT    = 1,   // 1 or 2; any value other than 1 builds the 2-stage path
  parameter int WR_FIRST  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [ADDR_BITS-1:0]   wr_addr_i,
  input  logic [DATA_BITS/8-1:0] wr_be_i,
  input  logic [DATA_BITS-1:0]   wr_data_i,
  input  logic                   rd_en_i,
  input  logic [ADDR_BITS-1:0]   rd_addr_i,
  output logic [DATA_BITS-1:0]   rd_data_o,
  output logic                   rd_valid_o,
  input  logic                   clr_i,
  output logic                   busy_o,
  output logic                   clr_done_o
);

  localparam int DEPTH   = 2 ** ADDR_BITS;
  localparam int BE_BITS = DATA_BITS / 8;

  logic                 busy;
  logic                 clr_we;
  logic [ADDR_BITS-1:0] clr_addr;
  logic                 clr_done;

  gbuff_clear_ctrl #(
    .ADDR_BITS (ADDR_BITS)
  ) u_clear_ctrl (
    .clk      (clk_i),
    .rst      (rst_i),
    .clr_req  (clr_i),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .done     (clr_done)
  );

  assign busy_o     = busy;
  assign clr_done_o = clr_done;

  // Requests in the same cycle as clr_i are still taken: busy rises a cycle later.
  logic wr_accept;
  logic rd_accept;
  assign wr_accept = wr_en_i & ~busy;
  assign rd_accept = rd_en_i & ~busy;

  // Storage: no reset so it maps onto block RAM. The clear engine owns the
  // write port while busy; user writes are gated off during that time.
  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_accept) begin
      for (int k = 0; k < BE_BITS; k++) begin
        if (wr_be_i[k]) begin
          mem[wr_addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
        end
      end
    end
  end

  // Read word with write-first bypass: on a same-address collision the
  // enabled bytes of the incoming write replace the stored bytes.
  logic [DATA_BITS-1:0] rd_word;
  logic                 collide;
  assign collide = wr_accept && (wr_addr_i == rd_addr_i);

  always_comb begin
    rd_word = mem[rd_addr_i];
    if ((WR_FIRST != 0) && collide) begin
      rd_word = DATA_BITS'(merge_bytes(MAX_DATA_BITS'(mem[rd_addr_i]),
                                       MAX_DATA_BITS'(wr_data_i),
                                       MAX_BE_BITS'(wr_be_i)));
    end
  end

  // First read stage: captures only on an accepted read so data holds.
  logic [DATA_BITS-1:0] s1_data_reg;
  logic                 s1_valid_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_data_reg  <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= rd_accept;
      if (rd_accept) begin
        s1_data_reg <= rd_word;
      end
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign rd_data_o  = s1_data_reg;
      assign rd_valid_o = s1_valid_reg;
    end else begin : g_lat2
      // Output register stage; in-flight reads finish even if a clear starts.
      logic [DATA_BITS-1:0] s2_data_reg;
      logic                 s2_valid_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s2_data_reg  <= '0;
          s2_valid_reg <= 1'b0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          if (s1_valid_reg) begin
            s2_data_reg <= s1_data_reg;
          end
        end
      end

      assign rd_data_o  = s2_data_reg;
      assign rd_valid_o = s2_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_global_buffer_dp.sv
// -----------------------------------------------------------------------------
// tb_global_buffer_dp
// Two instances share every input: u_a (RD_LAT=1, WR_FIRST=1) and
// u_b (RD_LAT=2, WR_FIRST=0), both with a 16-word array. Directed steps,
// expected values written by hand.
// -----------------------------------------------------------------------------
module tb_global_buffer_dp;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        clr;

  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  global_buffer_dp #(.ADDR_BITS(4), .DATA_BITS(32), .RD_LAT(1), .WR_FIRST(1)) u_a (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a),
    .clr_i(clr), .busy_o(busy_a), .clr_done_o(done_a)
  );

  global_buffer_dp #(.ADDR_BITS(4), .DATA_BITS(32), .RD_LAT(2), .WR_FIRST(0)) u_b (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b),
    .clr_i(clr), .busy_o(busy_b), .clr_done_o(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Called 1 time unit after a rising edge; leaves time at 1 unit after the next.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issues one read (plus any write already set up) and checks exact latency.
  task automatic read_chk(input string tag, input logic [3:0] a,
                          input logic [31:0] exp_a, input logic [31:0] exp_b);
    rd_en = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    chk({tag, " a_valid_lat1"}, 32'(rd_valid_a), 32'd1);
    chk({tag, " a_data"},       rd_data_a,       exp_a);
    chk({tag, " b_valid_early"},32'(rd_valid_b), 32'd0);
    $display("[TB] read %s addr %0d: a=%h b(pending)", tag, a, rd_data_a);
    @(posedge clk); #1;
    chk({tag, " a_valid_drop"}, 32'(rd_valid_a), 32'd0);
    chk({tag, " b_valid_lat2"}, 32'(rd_valid_b), 32'd1);
    chk({tag, " b_data"},       rd_data_b,       exp_b);
    $display("[TB] read %s addr %0d: b=%h", tag, a, rd_data_b);
  endtask

  task automatic fill_all(input logic [31:0] d);
    for (int i = 0; i < 16; i++) begin
      do_write(4'(i), d, 4'hF);
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; clr = 1'b0;

    // ---------------- reset state ----------------
    #1 rst = 1'b1;
    #1;
    chk("rst a_rd_data", rd_data_a, 32'h0);
    chk("rst b_rd_data", rd_data_b, 32'h0);
    chk("rst a_valid",   32'(rd_valid_a), 32'd0);
    chk("rst b_valid",   32'(rd_valid_b), 32'd0);
    chk("rst busy",      32'(busy_a | busy_b), 32'd0);
    chk("rst done",      32'(done_a | done_b), 32'd0);
    $display("[TB] reset: busy=%0d done=%0d valid=%0d/%0d", busy_a, done_a, rd_valid_a, rd_valid_b);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---------------- byte-enable write ----------------
    do_write(4'd5, 32'hAABBCCDD, 4'hF);
    do_write(4'd5, 32'h11223344, 4'h5);
    read_chk("byte_en", 4'd5, 32'hAA22CC44, 32'hAA22CC44);

    // ---------------- streaming reads ----------------
    for (int i = 0; i < 8; i++) begin
      do_write(4'(i), 32'(i * 3), 4'hF);
    end
    for (int k = 0; k < 8; k++) begin
      rd_en = 1'b1; rd_addr = 4'(k);
      @(posedge clk); #1;
      chk("stream a_valid", 32'(rd_valid_a), 32'd1);
      chk("stream a_data",  rd_data_a, 32'(k * 3));
      if (k == 0) begin
        chk("stream b_valid_first", 32'(rd_valid_b), 32'd0);
      end else begin
        chk("stream b_valid", 32'(rd_valid_b), 32'd1);
        chk("stream b_data",  rd_data_b, 32'((k - 1) * 3));
      end
      $display("[TB] stream cycle %0d: a=%h b=%h", k, rd_data_a, rd_data_b);
    end
    rd_en = 1'b0;
    @(posedge clk); #1;
    chk("stream a_valid_end", 32'(rd_valid_a), 32'd0);
    chk("stream b_valid_last", 32'(rd_valid_b), 32'd1);
    chk("stream b_data_last",  rd_data_b, 32'd21);
    chk("stream a_hold",       rd_data_a, 32'd21);
    $display("[TB] stream tail: b=%h", rd_data_b);

    // ---------------- collision ----------------
    do_write(4'd9, 32'h0, 4'hF);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hFFFFFFFF; wr_be = 4'h3;
    read_chk("collide", 4'd9, 32'h0000FFFF, 32'h00000000);
    read_chk("collide_after", 4'd9, 32'h0000FFFF, 32'h0000FFFF);

    // ---------------- clear ----------------
    fill_all(32'hDEADBEEF);
    clr = 1'b1; rd_en = 1'b1; rd_addr = 4'd2;   // read in the clr_i cycle is accepted
    @(posedge clk); #1;
    clr = 1'b0;
    rd_en = 1'b1; rd_addr = 4'd3;               // held through busy: must be ignored
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h12345678; wr_be = 4'hF;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      chk("clr busy_a", 32'(busy_a), 32'd1);
      chk("clr busy_b", 32'(busy_b), 32'd1);
      chk("clr done_early", 32'(done_a | done_b), 32'd0);
      chk("clr a_valid", 32'(rd_valid_a), (i == 0) ? 32'd1 : 32'd0);
      chk("clr a_data_hold", rd_data_a, 32'hDEADBEEF);
      chk("clr b_valid", 32'(rd_valid_b), (i == 1) ? 32'd1 : 32'd0);
      if (i == 1) chk("clr b_inflight_data", rd_data_b, 32'hDEADBEEF);
      $display("[TB] clear cycle %0d: busy=%0d valid=%0d/%0d", i, busy_a, rd_valid_a, rd_valid_b);
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    chk("clr busy_end", 32'(busy_a | busy_b), 32'd0);
    chk("clr done_a", 32'(done_a), 32'd1);
    chk("clr done_b", 32'(done_b), 32'd1);
    chk("clr valid_end", 32'(rd_valid_a | rd_valid_b), 32'd0);
    $display("[TB] clear end: busy=%0d done=%0d", busy_a, done_a);
    @(posedge clk); #1;
    chk("clr done_once", 32'(done_a | done_b), 32'd0);
    chk("clr valid_after", 32'(rd_valid_a | rd_valid_b), 32'd0);
    for (int i = 0; i < 16; i++) begin
      read_chk("cleared", 4'(i), 32'h0, 32'h0);
    end

    // ---------------- reset mid-clear ----------------
    fill_all(32'hDEADBEEF);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy_a | busy_b), 32'd0);
    chk("midrst valid", 32'(rd_valid_a | rd_valid_b), 32'd0);
    chk("midrst done", 32'(done_a | done_b), 32'd0);
    chk("midrst a_rd_data", rd_data_a, 32'h0);
    chk("midrst b_rd_data", rd_data_b, 32'h0);
    $display("[TB] reset mid-clear: busy=%0d done=%0d", busy_a, done_a);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("midrst no_done", 32'(done_a | done_b), 32'd0);
      chk("midrst no_busy", 32'(busy_a | busy_b), 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      read_chk("partial_cleared", 4'(i), 32'h0, 32'h0);
    end
    read_chk("partial_kept6", 4'd6, 32'hDEADBEEF, 32'hDEADBEEF);
    read_chk("partial_kept10", 4'd10, 32'hDEADBEEF, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/global_buffer_dp.md
Name: global_buffer_dp

Overview:
- Parametrised successor to the single-port global buffer: simple dual-port SRAM model with independent read and write ports, per-byte write enables, and configurable read latency (1 or 2).
- Built-in clear engine zeroes the whole array on request.
- Sits between the DMA/loader and the systolic array so operands can be filled and drained in the same cycle.

Parameters:
- ADDR_BITS, 8, word address width; DEPTH = 2**ADDR_BITS.
- DATA_BITS, 32, word width; must be a multiple of 8.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- WR_FIRST, 1, same-address read/write collision policy: 1 returns new data, 0 returns old data.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- wr_en_i  in  1  write request
- wr_addr_i  in  ADDR_BITS  write word address
- wr_be_i  in  DATA_BITS/8  byte enables; bit k covers data[8k+7:8k]
- wr_data_i  in  DATA_BITS  write data
- rd_en_i  in  1  read request
- rd_addr_i  in  ADDR_BITS  read word address
- rd_data_o  out  DATA_BITS  read data
- rd_valid_o  out  1  one-cycle pulse, rd_data_o is valid
- clr_i  in  1  start clear of whole array
- busy_o  out  1  clear in progress; ports ignored
- clr_done_o  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset: one clock, asynchronous, active-high.
  - Outputs on reset: rd_data_o=0, rd_valid_o=0, busy_o=0, clr_done_o=0, FSM=IDLE, clear counter=0, read pipeline flushed.
  - Array contents are not reset and are undefined until written or cleared.
- Write: at posedge with wr_en_i=1 and busy_o=0, update only the bytes whose wr_be_i bit is 1. wr_be_i=0 is a no-op.
- Read: at posedge with rd_en_i=1 and busy_o=0, the request is accepted.
  - rd_valid_o=1 and rd_data_o=mem[addr] exactly RD_LAT cycles later.
  - Back-to-back reads give one result per cycle, in order.
  - rd_data_o holds its last value when rd_valid_o=0.
- Collision (rd_addr_i==wr_addr_i, both enabled, same cycle):
  - WR_FIRST=1: returned word is old data with the enabled bytes replaced by wr_data_i (byte-wise merge).
  - WR_FIRST=0: returned word is the pre-write contents.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_i=1 -> CLEAR. busy_o=1 from the next cycle. Any rd/wr issued in the same cycle as clr_i is still accepted.
  - CLEAR: write 0 to mem[cnt] each cycle, cnt from 0 to DEPTH-1. At cnt==DEPTH-1 go to DONE. Takes exactly DEPTH cycles.
  - DONE: clr_done_o=1 for one cycle, busy_o=0, next state IDLE.
  - While busy_o=1: wr_en_i, rd_en_i and clr_i are ignored; no rd_valid_o is produced for them.
  - Reads already in the pipeline when CLEAR starts still complete with their pre-clear data.
  - Reset during CLEAR: back to IDLE and cnt=0; the array is left partially cleared; no clr_done_o pulse.
- Widths: cnt is ADDR_BITS wide; the terminal-count compare must not rely on overflow.
- RD_LAT=2 adds an output register stage after the array read. rd_valid_o is delayed to match.

Decomposition:
- Package gbuff_pkg:
  - clr_state_t enum {IDLE, CLEAR, DONE}
  - localparam BE_BITS = DATA_BITS/8
  - function merge_bytes(old, new, be) for the byte-wise merge
- Sub-module gbuff_clear_ctrl: FSM + counter.
  - Outputs busy, clr_we, clr_addr, done.
  - Top level muxes clear writes over the user write port.
- Array and read pipeline stay in the top level.

Test Plan:
- Byte-enable write (DATA_BITS=32): write 0xAABBCCDD to addr 5 with be=0xF, then 0x11223344 with be=0x5; read addr 5 -> rd_data_o=0xAA22CC44, valid exactly RD_LAT cycles after the request (check RD_LAT=1 and RD_LAT=2).
- Streaming reads: write addr 0..7 with value=addr*3; issue rd_en for 8 consecutive cycles, addr 0..7 -> 8 consecutive valid pulses carrying 0,3,6,...,21, in order.
- Collision: mem[9]=0x0; same cycle write 0xFFFFFFFF be=0x3 and read addr 9 -> WR_FIRST=1 returns 0x0000FFFF; WR_FIRST=0 returns 0x00000000; a follow-up read returns 0x0000FFFF in both cases.
- Clear (ADDR_BITS=4): fill all 16 words with 0xDEADBEEF; pulse clr_i -> busy_o high for 16 cycles, then clr_done_o pulses once; reads and writes issued while busy_o=1 produce no rd_valid_o and no change; afterwards every address reads 0.
- Reset mid-clear: assert rst_i asynchronously after 6 clear cycles -> busy_o, rd_valid_o, clr_done_o drop to 0 immediately; no done pulse; addr 0..5 read 0, addr 10 still reads 0xDEADBEEF.
